// File: rtl/pll_lock_sequencer_if.sv
// Control/status bundle between the PLL lock sequencer and its surroundings
// (PLL instance, reset tree, CSR block).
interface pll_lock_sequencer_if;
  logic       locked_async;
  logic       soft_reset;
  logic       pll_rst;
  logic       domain_reset_n;
  logic       fault;
  logic [2:0] state_o;
  logic [3:0] retry_count;
  logic [7:0] lock_lost_count;

  // Sequencer side
  modport master (
    input  locked_async,
    input  soft_reset,
    output pll_rst,
    output domain_reset_n,
    output fault,
    output state_o,
    output retry_count,
    output lock_lost_count
  );

  // PLL / reset-tree / CSR side
  modport slave (
    output locked_async,
    output soft_reset,
    input  pll_rst,
    input  domain_reset_n,
    input  fault,
    input  state_o,
    input  retry_count,
    input  lock_lost_count
  );
endinterface

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer: pulses the PLL reset, waits for lock with timeout
// and retries, qualifies lock as stable, then releases the PLL-output domain
// reset. Loss of lock in RUN re-runs the whole sequence.
module pll_lock_sequencer #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 65536,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned MAX_RETRIES   = 3,
  parameter int unsigned CNT_W         = 20
) (
  input  logic               clk,
  input  logic               reset_n,
  pll_lock_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [3:0]       RETRY_MAX   = 4'(MAX_RETRIES);

  logic             sync1;
  logic             locked_s;
  state_t           state;
  state_t           nxt_state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] nxt_cnt;
  logic [3:0]       retry;
  logic [3:0]       nxt_retry;
  logic [7:0]       lost;
  logic [7:0]       nxt_lost;

  assign bus.state_o         = state;
  assign bus.retry_count     = retry;
  assign bus.lock_lost_count = lost;

  // Next-state, shared counter, retry and lock-loss bookkeeping
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_retry = retry;
    nxt_lost  = lost;
    if (bus.soft_reset) begin
      nxt_state = RESET_PLL;
      nxt_cnt   = '0;
      nxt_retry = '0;
    end else begin
      case (state)
        RESET_PLL: begin
          if (cnt == RST_LAST) begin
            nxt_state = WAIT_LOCK;
            nxt_cnt   = '0;
          end else begin
            nxt_cnt = cnt + 1'b1;
          end
        end
        WAIT_LOCK: begin
          if (locked_s) begin
            nxt_state = STABLE;
            nxt_cnt   = '0;
          end else if (cnt == TIMEOUT_LAST) begin
            nxt_retry = retry + 4'd1;
            nxt_cnt   = '0;
            nxt_state = ((retry + 4'd1) == RETRY_MAX) ? FAULT : RESET_PLL;
          end else begin
            nxt_cnt = cnt + 1'b1;
          end
        end
        STABLE: begin
          if (!locked_s) begin
            nxt_state = WAIT_LOCK;
            nxt_cnt   = '0;
          end else if (cnt == STABLE_LAST) begin
            nxt_state = RUN;
            nxt_cnt   = '0;
            nxt_retry = '0;
          end else begin
            nxt_cnt = cnt + 1'b1;
          end
        end
        RUN: begin
          if (!locked_s) begin
            nxt_state = RESET_PLL;
            nxt_cnt   = '0;
            nxt_retry = '0;
            nxt_lost  = (lost == 8'hFF) ? lost : lost + 8'd1;
          end
        end
        FAULT: begin
          nxt_state = FAULT;
        end
        default: begin
          nxt_state = RESET_PLL;
          nxt_cnt   = '0;
        end
      endcase
    end
  end

  // State, synchronizer and registered outputs decoded from the next state,
  // so pll_rst/domain_reset_n/fault change in the same cycle as state_o
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1              <= 1'b0;
      locked_s           <= 1'b0;
      state              <= RESET_PLL;
      cnt                <= '0;
      retry              <= '0;
      lost               <= '0;
      bus.pll_rst        <= 1'b1;
      bus.domain_reset_n <= 1'b0;
      bus.fault          <= 1'b0;
    end else begin
      sync1              <= bus.locked_async;
      locked_s           <= sync1;
      state              <= nxt_state;
      cnt                <= nxt_cnt;
      retry              <= nxt_retry;
      lost               <= nxt_lost;
      bus.pll_rst        <= (nxt_state == RESET_PLL) || (nxt_state == FAULT);
      bus.domain_reset_n <= (nxt_state == RUN);
      bus.fault          <= (nxt_state == FAULT);
    end
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with small timing parameters.
module tb_pll_lock_sequencer;

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;

  pll_lock_sequencer_if bus ();

  pll_lock_sequencer #(
    .RST_CYCLES    (4),
    .LOCK_TIMEOUT  (32),
    .STABLE_CYCLES (8),
    .MAX_RETRIES   (2),
    .CNT_W         (20)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // domain reset only released in RUN
  a_dom_run: assert property (@(posedge clk) disable iff (!reset_n)
    bus.domain_reset_n |-> (bus.state_o == 3'd3))
    else begin
      failures++;
      $error("FAIL sva_dom_run observed state=%0d expected=3", bus.state_o);
    end

  // PLL reset and domain release are mutually exclusive
  a_excl: assert property (@(posedge clk) disable iff (!reset_n)
    !(bus.pll_rst && bus.domain_reset_n))
    else begin
      failures++;
      $error("FAIL sva_excl observed pll_rst=1 domain_reset_n=1 expected not both");
    end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
  endtask

  task automatic chk_outs(input string tag, input int pr, input int dr, input int f,
                          input int st, input int rc, input int lc);
    chk({tag, "_pll_rst"}, 32'(bus.pll_rst), pr);
    chk({tag, "_dom_rst_n"}, 32'(bus.domain_reset_n), dr);
    chk({tag, "_fault"}, 32'(bus.fault), f);
    chk({tag, "_state"}, 32'(bus.state_o), st);
    chk({tag, "_retry"}, 32'(bus.retry_count), rc);
    chk({tag, "_lost"}, 32'(bus.lock_lost_count), lc);
  endtask

  initial begin
    int exp_lost;
    checks           = 0;
    failures         = 0;
    reset_n          = 1'b0;
    bus.locked_async = 1'b0;
    bus.soft_reset   = 1'b0;

    // Reset values
    step(3);
    chk_outs("reset", 1, 0, 0, 0, 0, 0);

    // Test 1: basic lock and release
    reset_n = 1'b1;
    step(3);
    chk_outs("t1_pulse", 1, 0, 0, 0, 0, 0);
    step(1);
    chk_outs("t1_wait", 0, 0, 0, 1, 0, 0);
    step(10);
    chk("t1_still_wait", 32'(bus.state_o), 1);
    bus.locked_async = 1'b1;
    step(10);
    chk_outs("t1_stable", 0, 0, 0, 2, 0, 0);
    step(1);
    chk_outs("t1_run", 0, 1, 0, 3, 0, 0);

    // Test 3: lock glitch during STABLE (restart via soft_reset, lock held)
    bus.soft_reset = 1'b1;
    step(1);
    bus.soft_reset = 1'b0;
    chk_outs("t3_soft", 1, 0, 0, 0, 0, 0);
    step(4);
    chk("t3_wait", 32'(bus.state_o), 1);
    step(1);
    chk("t3_stable", 32'(bus.state_o), 2);
    step(3);
    bus.locked_async = 1'b0;
    step(2);
    chk("t3_still_stable", 32'(bus.state_o), 2);
    step(1);
    chk_outs("t3_back_wait", 0, 0, 0, 1, 0, 0);
    step(2);
    bus.locked_async = 1'b1;
    step(2);
    chk("t3_wait2", 32'(bus.state_o), 1);
    step(1);
    chk("t3_stable2", 32'(bus.state_o), 2);
    step(7);
    chk_outs("t3_pre_run", 0, 0, 0, 2, 0, 0);
    step(1);
    chk_outs("t3_run", 0, 1, 0, 3, 0, 0);

    // Test 4: repeated lock loss in RUN, counter saturates at 255
    for (int n = 1; n <= 260; n++) begin
      exp_lost = (n > 255) ? 255 : n;
      bus.locked_async = 1'b0;
      step(2);
      chk("t4_still_run", 32'(bus.domain_reset_n), 1);
      step(1);
      chk_outs("t4_lost", 1, 0, 0, 0, 0, exp_lost);
      bus.locked_async = 1'b1;
      step(3);
      chk("t4_pulse", 32'(bus.pll_rst), 1);
      step(1);
      chk("t4_wait", 32'(bus.state_o), 1);
      step(1);
      chk("t4_stable", 32'(bus.state_o), 2);
      step(8);
      chk("t4_run", 32'(bus.domain_reset_n), 1);
    end
    chk_outs("t4_final", 0, 1, 0, 3, 0, 255);

    // Test 2: no lock -> two attempts -> FAULT after 72 cycles
    bus.locked_async = 1'b0;
    bus.soft_reset   = 1'b1;
    step(1);
    bus.soft_reset = 1'b0;
    chk_outs("t2_soft", 1, 0, 0, 0, 0, 255);
    step(3);
    chk("t2_pulse1", 32'(bus.pll_rst), 1);
    step(1);
    chk_outs("t2_wait1", 0, 0, 0, 1, 0, 255);
    step(31);
    chk_outs("t2_wait1_end", 0, 0, 0, 1, 0, 255);
    step(1);
    chk_outs("t2_retry1", 1, 0, 0, 0, 1, 255);
    step(3);
    chk("t2_pulse2", 32'(bus.pll_rst), 1);
    step(1);
    chk_outs("t2_wait2", 0, 0, 0, 1, 1, 255);
    step(31);
    chk_outs("t2_wait2_end", 0, 0, 0, 1, 1, 255);
    step(1);
    chk_outs("t2_fault", 1, 0, 1, 4, 2, 255);
    step(200);
    chk_outs("t2_fault_hold", 1, 0, 1, 4, 2, 255);

    // Test 5: soft_reset out of FAULT, then normal release
    bus.soft_reset   = 1'b1;
    bus.locked_async = 1'b1;
    step(1);
    bus.soft_reset = 1'b0;
    chk_outs("t5_soft", 1, 0, 0, 0, 0, 255);
    step(4);
    chk("t5_wait", 32'(bus.state_o), 1);
    step(1);
    chk("t5_stable", 32'(bus.state_o), 2);
    step(7);
    chk("t5_pre_run", 32'(bus.domain_reset_n), 0);
    step(1);
    chk_outs("t5_run", 0, 1, 0, 3, 0, 255);

    // Async reset mid-STABLE, no clock edge needed
    bus.soft_reset = 1'b1;
    step(1);
    bus.soft_reset = 1'b0;
    step(5);
    chk("t5_in_stable", 32'(bus.state_o), 2);
    #2;
    reset_n = 1'b0;
    #1;
    chk_outs("t5_async_rst", 1, 0, 0, 0, 0, 0);
    step(2);
    chk_outs("t5_rst_hold", 1, 0, 0, 0, 0, 0);
    reset_n = 1'b1;

    // Test 6: random lock glitches, invariants checked every cycle
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) bus.locked_async = ~bus.locked_async;
      bus.soft_reset = ($urandom_range(0, 99) == 0);
      step(1);
      chk("t6_dom_outside_run",
          32'(bus.domain_reset_n && (bus.state_o != 3'd3)), 0);
      chk("t6_both_high", 32'(bus.pll_rst && bus.domain_reset_n), 0);
      chk("t6_fault_state", 32'(bus.fault), 32'(bus.state_o == 3'd4));
    end
    bus.soft_reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
